// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between two requesters, the shared ALU and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req0_ready_c;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             req1_ready_c;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_lt;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_lt;
  logic             rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready_c,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready_c,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_zero, alu_lt,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_lt,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready_c,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready_c,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_zero, alu_lt,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_lt,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU; one operation in flight,
// result returned on a tagged valid/ready response port.
module alu_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter bit          FAIR  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;
  logic   gnt_any_c;
  logic   gnt_id_c;
  logic   accept_c;
  logic   capture_c;
  logic   release_c;

  // Lone requester wins outright; on contention the pointer (or requester 0) wins.
  always_comb begin
    gnt_any_c = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid & bus.req1_valid) begin
      gnt_id_c = FAIR ? ptr_q : 1'b0;
    end else begin
      gnt_id_c = bus.req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    accept_c         = 1'b0;
    capture_c        = 1'b0;
    release_c        = 1'b0;
    bus.req0_ready_c = 1'b0;
    bus.req1_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          accept_c         = 1'b1;
          bus.req0_ready_c = ~gnt_id_c;
          bus.req1_ready_c = gnt_id_c;
          state_d          = EXEC;
        end
      end
      EXEC: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
          // Hand contention priority to whoever was not just served.
          if (FAIR) begin
            ptr_d = ~bus.rsp_id;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= 2'b00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_lt    <= 1'b0;
    end else begin
      if (accept_c) begin
        bus.alu_a  <= gnt_id_c ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= gnt_id_c ? bus.req1_b  : bus.req0_b;
        bus.alu_op <= gnt_id_c ? bus.req1_op : bus.req0_op;
        bus.rsp_id <= gnt_id_c;
      end
      if (capture_c) begin
        bus.rsp_data  <= bus.alu_out;
        bus.rsp_zero  <= bus.alu_zero;
        bus.rsp_lt    <= bus.alu_lt;
        bus.rsp_valid <= 1'b1;
      end else if (release_c) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule
